// File: rtl/hs_rr_arbiter.sv
// ============================================================================
// Module   : hs_rr_arbiter
// Purpose  : Round-robin arbiter with a per-grant burst cap. It feeds one
//            consumer through a 2-entry registered output buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            up_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] up_data,
  output logic [NUM_REQ-1:0]            up_ready,
  output logic                          down_valid,
  output logic [WORD_WIDTH-1:0]         down_data,
  output logic [ID_WIDTH-1:0]           down_id,
  input  logic                          down_ready
);

  localparam int                  CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0] LAST_REQ  = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [1:0]          OCC_FULL  = 2'd2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First requester set in req, scanning base+1, base+2, ... and wrapping so base is last.
  function automatic logic [ID_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0]  req,
                                                  input logic [ID_WIDTH-1:0] base);
    logic [2*NUM_REQ-1:0]  dbl;
    logic [NUM_REQ-1:0]    rot;
    logic [NUM_REQ-1:0]    probe;
    logic [ID_WIDTH-1:0]   pick;
    logic                  found;
    int                    idx;
    dbl   = {req, req};
    rot   = NUM_REQ'(dbl >> (int'(base) + 1));
    pick  = base;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = rot >> k;
      if (!found && probe[0]) begin
        idx = int'(base) + 1 + k;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
        pick  = ID_WIDTH'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [1:0]            occ_q, occ_d;
  logic [NUM_REQ-1:0]    up_ready_q, up_ready_d;
  logic                  down_valid_q, down_valid_d;
  logic [WORD_WIDTH-1:0] data0_q, data0_d;
  logic [WORD_WIDTH-1:0] data1_q, data1_d;
  logic [ID_WIDTH-1:0]   id0_q, id0_d;
  logic [ID_WIDTH-1:0]   id1_q, id1_d;

  logic [NUM_REQ-1:0]    grant_onehot;
  logic                  grant_valid;
  logic [WORD_WIDTH-1:0] up_word;
  logic                  up_xfer;
  logic                  down_xfer;
  logic                  burst_done;
  logic                  grant_release;

  always_comb begin
    grant_onehot = NUM_REQ'(1) << grant_q;
    grant_valid  = |(up_valid & grant_onehot);
    up_word      = WORD_WIDTH'(up_data >> (int'(grant_q) * WORD_WIDTH));
    up_xfer      = |(up_ready_q & up_valid);
    down_xfer    = down_valid_q & down_ready;
  end

  // Output buffer: entry 0 faces the consumer, entry 1 catches the beat that
  // arrives while entry 0 is stalled.
  always_comb begin
    occ_d   = occ_q;
    data0_d = data0_q;
    id0_d   = id0_q;
    data1_d = data1_q;
    id1_d   = id1_q;
    case (occ_q)
      2'd0: begin
        if (up_xfer) begin
          data0_d = up_word;
          id0_d   = grant_q;
          occ_d   = 2'd1;
        end
      end
      2'd1: begin
        if (up_xfer && down_xfer) begin
          data0_d = up_word;
          id0_d   = grant_q;
        end else if (up_xfer) begin
          data1_d = up_word;
          id1_d   = grant_q;
          occ_d   = 2'd2;
        end else if (down_xfer) begin
          occ_d   = 2'd0;
        end
      end
      2'd2: begin
        if (down_xfer) begin
          data0_d = data1_q;
          id0_d   = id1_q;
          occ_d   = 2'd1;
        end
      end
      default: begin
        occ_d = 2'd0;
      end
    endcase
    down_valid_d = (occ_d != 2'd0);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    burst_done    = 1'b0;
    grant_release = 1'b0;
    case (state_q)
      IDLE: begin
        if (|up_valid) begin
          grant_d    = rr_pick(up_valid, last_grant_q);
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (up_xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        burst_done    = up_xfer && (beat_cnt_q == LAST_BEAT);
        // A full-buffer stall keeps up_valid high, so it never releases here.
        grant_release = burst_done || !grant_valid;
        if (grant_release) begin
          last_grant_d = grant_q;
          beat_cnt_d   = '0;
          if (|up_valid) begin
            grant_d = rr_pick(up_valid, grant_q);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Ready is computed from next-cycle state so it can be driven straight from a flop.
    up_ready_d = '0;
    if ((state_d == GRANT) && (occ_d != OCC_FULL)) begin
      up_ready_d = NUM_REQ'(1) << grant_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_REQ;
      beat_cnt_q   <= '0;
      occ_q        <= 2'd0;
      up_ready_q   <= '0;
      down_valid_q <= 1'b0;
      data0_q      <= '0;
      id0_q        <= '0;
      data1_q      <= '0;
      id1_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      occ_q        <= occ_d;
      up_ready_q   <= up_ready_d;
      down_valid_q <= down_valid_d;
      data0_q      <= data0_d;
      id0_q        <= id0_d;
      data1_q      <= data1_d;
      id1_q        <= id1_d;
    end
  end

  assign up_ready   = up_ready_q;
  assign down_valid = down_valid_q;
  assign down_data  = data0_q;
  assign down_id    = id0_q;

endmodule

`default_nettype wire

// File: tb/tb_hs_rr_arbiter.sv
// ============================================================================
// Module   : tb_hs_rr_arbiter
// Purpose  : Directed and random stimulus for hs_rr_arbiter. Outputs are checked
//            against a queue-based reference model and a per-source scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hs_rr_arbiter;

  localparam int N   = 4;
  localparam int WW  = 8;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    up_valid;
  logic [N*WW-1:0] up_data;
  logic [N-1:0]    up_ready;
  logic            down_valid;
  logic [WW-1:0]   down_data;
  logic [IDW-1:0]  down_id;
  logic            down_ready;

  hs_rr_arbiter #(
    .NUM_REQ   (N),
    .WORD_WIDTH(WW),
    .MAX_BURST (MB),
    .ID_WIDTH  (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid),
    .up_data   (up_data),
    .up_ready  (up_ready),
    .down_valid(down_valid),
    .down_data (down_data),
    .down_id   (down_id),
    .down_ready(down_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         id;
  } beat_t;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state
  beat_t      m_buf[$];
  bit         m_gnt;
  bit         m_rdy;
  int         m_g;
  int         m_last;
  int         m_cnt;

  // Observation state
  beat_t      log_q[$];
  int         log_cyc[$];
  beat_t      sb_all[$];
  int         cyc = 0;
  int         up_total = 0;
  int         wait_cnt[N];
  logic [N-1:0] xfer_mask = '0;

  // Requester drivers
  int         rem[N];
  logic [7:0] nxt[N];
  bit         rand_mode = 0;

  // Scratch for the monitor process
  logic [N-1:0] exp_ur;
  bit           m_upx, m_dnx;
  beat_t        tmp_b;
  int           found_at;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit vbit(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [7:0] word_of(input logic [N*WW-1:0] d, input int i);
    return 8'(d >> (i * WW));
  endfunction

  // Round-robin: first valid requester after 'from', wrapping, 'from' itself last.
  function automatic int pick(input logic [N-1:0] v, input int from);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (from + k) % N;
      if (vbit(v, j)) return j;
    end
    return from;
  endfunction

  // Monitor: mid-cycle compare, then advance the model across the coming edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_buf.delete();
      sb_all.delete();
      m_gnt  = 0;
      m_rdy  = 0;
      m_last = N - 1;
      m_cnt  = 0;
      xfer_mask = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      chk("down_valid", 32'(down_valid), 32'(m_buf.size() != 0));
      exp_ur = m_rdy ? (N'(1) << m_g) : '0;
      chk("up_ready", 32'(up_ready), 32'(exp_ur));
      if (m_buf.size() != 0) begin
        chk("down_data", 32'(down_data), 32'(m_buf[0].data));
        chk("down_id", 32'(down_id), 32'(m_buf[0].id));
      end
      n_checks++;
      if ($countones(up_ready) > 1) begin
        n_errs++;
        $display("FAIL up_ready_onehot: got %b expected at most one bit", up_ready);
      end

      if (down_valid && down_ready) begin
        tmp_b.data = down_data;
        tmp_b.id   = int'(down_id);
        log_q.push_back(tmp_b);
        log_cyc.push_back(cyc);
        found_at = -1;
        for (int k = 0; k < sb_all.size(); k++) begin
          if (found_at < 0 && sb_all[k].id == int'(down_id)) found_at = k;
        end
        n_checks++;
        if (found_at < 0) begin
          n_errs++;
          $display("FAIL sb_order id%0d: got data %0h expected no beat (none pending)", down_id, down_data);
        end else begin
          if (sb_all[found_at].data !== down_data) begin
            n_errs++;
            $display("FAIL sb_order id%0d: got data %0h expected %0h", down_id, down_data, sb_all[found_at].data);
          end
          sb_all.delete(found_at);
        end
      end

      xfer_mask = up_ready & up_valid;
      for (int i = 0; i < N; i++) begin
        if (vbit(xfer_mask, i)) begin
          tmp_b.data = word_of(up_data, i);
          tmp_b.id   = i;
          sb_all.push_back(tmp_b);
          up_total++;
          wait_cnt[i] = 0;
        end else if (vbit(up_valid, i) && xfer_mask != '0) begin
          wait_cnt[i]++;
          n_checks++;
          if (wait_cnt[i] > (N - 1) * MB) begin
            n_errs++;
            $display("FAIL starvation req%0d: got %0d beats waited expected <= %0d", i, wait_cnt[i], (N - 1) * MB);
          end
        end
      end

      m_upx = m_gnt && m_rdy && vbit(up_valid, m_g);
      m_dnx = (m_buf.size() != 0) && down_ready;
      if (m_dnx) void'(m_buf.pop_front());
      if (m_upx) begin
        tmp_b.data = word_of(up_data, m_g);
        tmp_b.id   = m_g;
        m_buf.push_back(tmp_b);
      end
      if (!m_gnt) begin
        if (up_valid != '0) begin
          m_g   = pick(up_valid, m_last);
          m_cnt = 0;
          m_gnt = 1;
        end
      end else begin
        if (m_upx) m_cnt++;
        if ((m_upx && m_cnt == MB) || !vbit(up_valid, m_g)) begin
          m_last = m_g;
          m_cnt  = 0;
          if (up_valid != '0) m_g = pick(up_valid, m_g);
          else m_gnt = 0;
        end
      end
      m_rdy = m_gnt && (m_buf.size() < 2);
    end
  end

  // Requesters hold valid until their beat is taken, then advance their data.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (vbit(xfer_mask, i)) begin
        if (rem[i] > 0) rem[i]--;
        nxt[i]++;
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 2) == 0) rem[i] = $urandom_range(1, 6);
      end
      down_ready = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < N; i++) begin
      up_valid[i]        = (rem[i] != 0);
      up_data[i*WW +: WW] = nxt[i];
    end
  end

  task automatic wait_beats(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (log_q.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    n_checks++;
    if (log_q.size() < n) begin
      n_errs++;
      $display("FAIL %s timeout: got %0d beats expected %0d", tag, log_q.size(), n);
    end
  endtask

  task automatic check_log(input string tag, input int ids[$], input int bases[N]);
    int    seen[N];
    beat_t b;
    for (int i = 0; i < N; i++) seen[i] = 0;
    for (int k = 0; k < ids.size(); k++) begin
      if (k < log_q.size()) begin
        b = log_q[k];
      end else begin
        b.data = 8'hxx;
        b.id   = -1;
      end
      chk($sformatf("%s id[%0d]", tag, k), 32'(b.id), 32'(ids[k]));
      chk($sformatf("%s data[%0d]", tag, k), 32'(b.data), 32'(8'(bases[ids[k]] + seen[ids[k]])));
      seen[ids[k]]++;
    end
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ids[$];
    int bases[N];
    int up_base;
    int c;

    rst        = 1'b1;
    down_ready = 1'b0;
    up_valid   = '0;
    up_data    = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      nxt[i] = 8'h00;
      bases[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset down_valid", 32'(down_valid), 32'h0);
    chk("reset up_ready", 32'(up_ready), 32'h0);
    chk("reset down_data", 32'(down_data), 32'h0);
    chk("reset down_id", 32'(down_id), 32'h0);

    // Consumer stalled: exactly two beats are taken, then drained in order
    @(posedge clk); #1;
    clear_log();
    down_ready = 1'b0;
    up_base    = up_total;
    rem[0]     = 6;
    nxt[0]     = 8'h40;
    repeat (10) @(posedge clk);
    #3;
    chk("stall up_ready", 32'(up_ready), 32'h0);
    chk("stall down_valid", 32'(down_valid), 32'h1);
    chk("stall accepted", 32'(up_total - up_base), 32'd2);
    chk("stall head data", 32'(down_data), 32'h40);
    @(posedge clk); #1;
    down_ready = 1'b1;
    wait_beats("drain", 6, 60);
    repeat (5) @(posedge clk);
    #3;
    chk("drain count", 32'(log_q.size()), 32'd6);
    ids = '{0, 0, 0, 0, 0, 0};
    bases[0] = 8'h40;
    check_log("drain", ids, bases);

    // Reset mid-burst with the buffer full
    @(posedge clk); #1;
    clear_log();
    down_ready = 1'b0;
    rem[1]     = 6;
    nxt[1]     = 8'h50;
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst down_valid", 32'(down_valid), 32'h0);
    chk("midrst up_ready", 32'(up_ready), 32'h0);
    chk("midrst down_data", 32'(down_data), 32'h0);
    chk("midrst down_id", 32'(down_id), 32'h0);
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // All requesters: req0 first, then bursts of MAX_BURST in rotation
    @(posedge clk); #1;
    clear_log();
    down_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      rem[i]   = 5;
      nxt[i]   = 8'(i * 16);
      bases[i] = i * 16;
    end
    wait_beats("rotate", 20, 120);
    ids = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0, 1, 2, 3};
    check_log("rotate", ids, bases);

    // Lone requester: regranted every MAX_BURST beats with no bubble
    @(posedge clk); #1;
    clear_log();
    rem[2]   = 8;
    nxt[2]   = 8'h10;
    bases[2] = 8'h10;
    wait_beats("lone", 8, 60);
    ids = '{2, 2, 2, 2, 2, 2, 2, 2};
    check_log("lone", ids, bases);
    if (log_cyc.size() >= 8) chk("lone no bubble", 32'(log_cyc[7] - log_cyc[0]), 32'd7);

    // req1 drops valid after two beats while req3 waits
    @(posedge clk); #1;
    clear_log();
    rem[1]   = 2;
    nxt[1]   = 8'h20;
    bases[1] = 8'h20;
    bases[3] = 8'h30;
    @(posedge clk); #1;
    rem[3] = 8;
    nxt[3] = 8'h30;
    c = 0;
    do begin
      @(posedge clk); #3;
      c++;
    end while (rem[1] != 0 && c < 40);
    @(posedge clk); #1;
    rem[1] = 5;
    wait_beats("drop", 15, 80);
    ids = '{1, 1, 3, 3, 3, 3, 1, 1, 1, 1, 3, 3, 3, 3, 1};
    check_log("drop", ids, bases);

    // Random traffic and backpressure
    @(posedge clk); #1;
    rand_mode = 1;
    repeat (10000) @(posedge clk);
    #1;
    rand_mode  = 0;
    down_ready = 1'b1;
    c = 0;
    do begin
      @(posedge clk); #3;
      c++;
    end while ((rem[0] != 0 || rem[1] != 0 || rem[2] != 0 || rem[3] != 0 || down_valid) && c < 300);
    @(negedge clk); #1;
    chk("final down_valid", 32'(down_valid), 32'h0);
    chk("final pending beats", 32'(sb_all.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
